// File: rtl/mem_access_pkg.sv
// Shared constants, bus payload type and opcode helpers for the MEM stage.
package mem_access_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned OP_W   = 8;
    localparam int unsigned EXC_W  = 32;

    localparam logic [OP_W-1:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [OP_W-1:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [OP_W-1:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [OP_W-1:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [OP_W-1:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [OP_W-1:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [OP_W-1:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [OP_W-1:0] EXE_SW_OP  = 8'b1110_1011;

    localparam int unsigned EXC_ADEL = 4;
    localparam int unsigned EXC_ADES = 5;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam logic [REG_W-1:0]  NOP_REG_ADDR  = '0;
    localparam logic              WRITE_DISABLE = 1'b0;
    localparam logic [DATA_W-1:0] ZERO_WORD     = '0;

    typedef struct packed {
        logic              wr;
        logic [1:0]        size;
        logic [31:0]       addr;
        logic [DATA_W-1:0] wdata;
    } bus_req_t;

    function automatic logic is_load_op(input logic [OP_W-1:0] op);
        return op inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP};
    endfunction

    function automatic logic is_store_op(input logic [OP_W-1:0] op);
        return op inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
    endfunction

    function automatic logic [1:0] op_size(input logic [OP_W-1:0] op);
        case (op)
            EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: return SIZE_BYTE;
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return SIZE_HALF;
            default:                          return SIZE_WORD;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// SRAM-like data bus with separate address and data handshakes.
interface mem_access_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [ADDR_W-1:0] data_addr;
    logic [31:0]       data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [31:0]       data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/mem_align.sv
// Byte-lane steering for stores, load extract/extend, and alignment check.
module mem_align
    import mem_access_pkg::*;
(
    input  logic [OP_W-1:0]   aluop,
    input  logic [1:0]        addr_lo,
    input  logic [DATA_W-1:0] reg2,
    input  logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] store_data_c,
    output logic [DATA_W-1:0] load_data_c,
    output logic              misalign_c
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [1:0]  size;

    always_comb begin
        size     = op_size(aluop);
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (addr_lo)
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            2'd3:    byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase

        case (size)
            SIZE_BYTE: store_data_c = {4{reg2[7:0]}};
            SIZE_HALF: store_data_c = {2{reg2[15:0]}};
            default:   store_data_c = reg2;
        endcase

        case (aluop)
            EXE_LB_OP:  load_data_c = {{24{byte_sel[7]}}, byte_sel};
            EXE_LBU_OP: load_data_c = {24'h0, byte_sel};
            EXE_LH_OP:  load_data_c = {{16{half_sel[15]}}, half_sel};
            EXE_LHU_OP: load_data_c = {16'h0, half_sel};
            default:    load_data_c = rdata;
        endcase

        misalign_c = (is_load_op(aluop) || is_store_op(aluop)) &&
                     (((size == SIZE_HALF) && addr_lo[0]) ||
                      ((size == SIZE_WORD) && (addr_lo != 2'd0)));
    end
endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: bus loads/stores with stall, alignment exceptions and
// zero-latency pass-through of non-memory results.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned KEEP_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              advance,
    input  logic [REG_W-1:0]  mem_wd_i,
    input  logic              mem_wreg_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    input  logic [OP_W-1:0]   mem_aluop_i,
    input  logic [31:0]       mem_addr_i,
    input  logic [DATA_W-1:0] mem_reg2_i,
    input  logic [EXC_W-1:0]  mem_except_type_i,
    mem_access_if.master      bus,
    output logic [REG_W-1:0]  wd_o,
    output logic              wreg_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic [EXC_W-1:0]  except_type_o,
    output logic [31:0]       bad_vaddr_o,
    output logic              stallreq
);
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_REQ   = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;

    if (KEEP_CYCLES > 0) begin : g_keep_reserved
    end

    logic [2:0]        state_q, state_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    bus_req_t          bus_q, bus_d;

    logic              is_load, is_store, misalign, valid_mem, access_ok;
    logic [DATA_W-1:0] store_data, load_data;

    mem_align u_align (
        .aluop        (mem_aluop_i),
        .addr_lo      (mem_addr_i[1:0]),
        .reg2         (mem_reg2_i),
        .rdata        (bus.data_rdata),
        .store_data_c (store_data),
        .load_data_c  (load_data),
        .misalign_c   (misalign)
    );

    assign is_load   = is_load_op(mem_aluop_i);
    assign is_store  = is_store_op(mem_aluop_i);
    assign valid_mem = (is_load || is_store) && !misalign && (mem_except_type_i == '0);
    assign access_ok = valid_mem && !flush;

    // State, captured load value and the held bus request
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rdata_q <= '0;
            bus_q   <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            bus_q   <= bus_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        bus_d   = bus_q;
        case (state_q)
            ST_IDLE: begin
                if (access_ok) begin
                    state_d = ST_REQ;
                    bus_d   = '{wr: is_store, size: op_size(mem_aluop_i),
                                addr: mem_addr_i, wdata: store_data};
                end
            end
            ST_REQ: begin
                // An accepted request must have its data phase drained on flush
                if (flush) begin
                    if (bus.data_addr_ok && !bus.data_data_ok) state_d = ST_DRAIN;
                    else                                        state_d = ST_IDLE;
                end else if (bus.data_addr_ok) begin
                    if (bus.data_data_ok) begin
                        state_d = ST_DONE;
                        rdata_d = load_data;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (flush) begin
                    state_d = bus.data_data_ok ? ST_IDLE : ST_DRAIN;
                end else if (bus.data_data_ok) begin
                    state_d = ST_DONE;
                    rdata_d = load_data;
                end
            end
            ST_DONE: begin
                if (flush || advance) state_d = ST_IDLE;
            end
            ST_DRAIN: begin
                if (bus.data_data_ok) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.data_req   = (state_q == ST_REQ);
    assign bus.data_wr    = bus_q.wr;
    assign bus.data_size  = bus_q.size;
    assign bus.data_addr  = ADDR_W'(bus_q.addr);
    assign bus.data_wdata = bus_q.wdata;

    // Outputs toward MEM/WB follow the stage inputs with no added latency
    always_comb begin
        wd_o          = NOP_REG_ADDR;
        wreg_o        = WRITE_DISABLE;
        wdata_o       = ZERO_WORD;
        except_type_o = '0;
        bad_vaddr_o   = '0;
        stallreq      = 1'b0;
        if (!rst) begin
            wd_o    = mem_wd_i;
            wreg_o  = mem_wreg_i && !misalign && !flush;
            wdata_o = is_load ? rdata_q : mem_wdata_i;
            if (!flush) begin
                except_type_o = mem_except_type_i;
                if (misalign) begin
                    except_type_o[EXC_ADEL] = except_type_o[EXC_ADEL] | is_load;
                    except_type_o[EXC_ADES] = except_type_o[EXC_ADES] | is_store;
                    bad_vaddr_o             = mem_addr_i;
                end
            end
            stallreq = (state_q == ST_DRAIN) ||
                       (access_ok && ((state_q == ST_IDLE) || (state_q == ST_REQ) ||
                                      (state_q == ST_WAIT)));
        end
    end
endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: loads, stores, misalignment, flush, hold, reset.
module tb_mem_access;
    import mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, advance;
    logic [4:0]  mem_wd_i;
    logic        mem_wreg_i;
    logic [31:0] mem_wdata_i, mem_addr_i, mem_reg2_i, mem_except_type_i;
    logic [7:0]  mem_aluop_i;
    logic [4:0]  wd_o;
    logic        wreg_o, stallreq;
    logic [31:0] wdata_o, except_type_o, bad_vaddr_o;
    int          checks = 0;
    int          failures = 0;
    int          stall_cycles;

    mem_access_if #(.ADDR_W(32)) bus ();

    mem_access #(.ADDR_W(32), .KEEP_CYCLES(0)) dut (
        .clk               (clk),
        .rst               (rst),
        .flush             (flush),
        .advance           (advance),
        .mem_wd_i          (mem_wd_i),
        .mem_wreg_i        (mem_wreg_i),
        .mem_wdata_i       (mem_wdata_i),
        .mem_aluop_i       (mem_aluop_i),
        .mem_addr_i        (mem_addr_i),
        .mem_reg2_i        (mem_reg2_i),
        .mem_except_type_i (mem_except_type_i),
        .bus               (bus),
        .wd_o              (wd_o),
        .wreg_o            (wreg_o),
        .wdata_o           (wdata_o),
        .except_type_o     (except_type_o),
        .bad_vaddr_o       (bad_vaddr_o),
        .stallreq          (stallreq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [7:0] op, input logic [31:0] addr,
                          input logic [31:0] reg2, input logic [4:0] wd, input logic wreg);
        mem_aluop_i       = op;
        mem_addr_i        = addr;
        mem_reg2_i        = reg2;
        mem_wd_i          = wd;
        mem_wreg_i        = wreg;
        mem_wdata_i       = 32'h0;
        mem_except_type_i = 32'h0;
    endtask

    task automatic slave(input logic aok, input logic dok, input logic [31:0] rd);
        bus.data_addr_ok = aok;
        bus.data_data_ok = dok;
        bus.data_rdata   = rd;
    endtask

    // Load with addr_ok and data_ok together on the first request cycle; ends in DONE
    task automatic run_load(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] rd);
        set_op(op, addr, 32'h0, 5'd2, 1'b1);
        tick();
        slave(1'b1, 1'b1, rd);
        tick();
        slave(1'b0, 1'b0, 32'hFFFF_FFFF);
        #1;
    endtask

    task automatic retire();
        advance = 1'b1;
        tick();
        advance = 1'b0;
        set_op(8'h00, 32'h0, 32'h0, 5'd0, 1'b0);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; advance = 1'b0;
        set_op(EXE_LW_OP, 32'h100, 32'h0, 5'd7, 1'b1);
        mem_wdata_i = 32'h1234_5678;
        slave(1'b0, 1'b0, 32'h0);
        tick(); tick();
        chk("rst_wd", 32'(wd_o), 32'h0);
        chk("rst_wreg", 32'(wreg_o), 32'h0);
        chk("rst_wdata", wdata_o, 32'h0);
        chk("rst_exc", except_type_o, 32'h0);
        chk("rst_bad", bad_vaddr_o, 32'h0);
        chk("rst_stall", 32'(stallreq), 32'h0);
        chk("rst_req", 32'(bus.data_req), 32'h0);
        set_op(8'h00, 32'h0, 32'h0, 5'd0, 1'b0);
        rst = 1'b0;
        tick();

        // Pass-through of a non-memory op
        set_op(8'h21, 32'h0, 32'h0, 5'd9, 1'b1);
        mem_wdata_i = 32'hA5A5_0001;
        #1;
        chk("pass_wdata", wdata_o, 32'hA5A5_0001);
        chk("pass_wd", 32'(wd_o), 32'd9);
        chk("pass_stall", 32'(stallreq), 32'h0);
        tick();
        chk("pass_req", 32'(bus.data_req), 32'h0);

        // LW 0x100: addr_ok two cycles in, data_ok three cycles later
        stall_cycles = 0;
        set_op(EXE_LW_OP, 32'h100, 32'h0, 5'd3, 1'b1);
        #1;
        chk("lw_c0_req", 32'(bus.data_req), 32'h0);
        stall_cycles += int'(stallreq);
        tick();
        chk("lw_c1_req", 32'(bus.data_req), 32'h1);
        chk("lw_c1_addr", bus.data_addr, 32'h100);
        chk("lw_c1_size", 32'(bus.data_size), 32'h2);
        chk("lw_c1_wr", 32'(bus.data_wr), 32'h0);
        stall_cycles += int'(stallreq);
        tick();
        slave(1'b1, 1'b0, 32'h0);
        #1;
        chk("lw_c2_req", 32'(bus.data_req), 32'h1);
        stall_cycles += int'(stallreq);
        tick();
        slave(1'b0, 1'b0, 32'h0);
        #1;
        chk("lw_c3_req", 32'(bus.data_req), 32'h0);
        stall_cycles += int'(stallreq);
        tick();
        stall_cycles += int'(stallreq);
        tick();
        slave(1'b0, 1'b1, 32'hDEAD_BEEF);
        #1;
        stall_cycles += int'(stallreq);
        tick();
        slave(1'b0, 1'b0, 32'h0);
        #1;
        stall_cycles += int'(stallreq);
        chk("lw_stall_cycles", 32'(stall_cycles), 32'd6);
        chk("lw_wdata", wdata_o, 32'hDEAD_BEEF);
        chk("lw_wreg", 32'(wreg_o), 32'h1);
        retire();
        chk("lw_after_stall", 32'(stallreq), 32'h0);

        // Lane select and extension
        run_load(EXE_LB_OP, 32'h103, 32'h8011_2233);
        chk("lb_103", wdata_o, 32'hFFFF_FF80);
        retire();
        run_load(EXE_LBU_OP, 32'h103, 32'h8011_2233);
        chk("lbu_103", wdata_o, 32'h0000_0080);
        retire();
        run_load(EXE_LHU_OP, 32'h102, 32'h8011_2233);
        chk("lhu_102", wdata_o, 32'h0000_8011);
        retire();
        run_load(EXE_LH_OP, 32'h102, 32'h8011_2233);
        chk("lh_102", wdata_o, 32'hFFFF_8011);
        retire();
        run_load(EXE_LB_OP, 32'h100, 32'h8011_2233);
        chk("lb_100", wdata_o, 32'h0000_0033);
        retire();

        // SH 0x206: separate address and data phases
        set_op(EXE_SH_OP, 32'h206, 32'h1234_ABCD, 5'd0, 1'b0);
        tick();
        chk("sh_req", 32'(bus.data_req), 32'h1);
        chk("sh_wr", 32'(bus.data_wr), 32'h1);
        chk("sh_size", 32'(bus.data_size), 32'h1);
        chk("sh_wdata", bus.data_wdata, 32'hABCD_ABCD);
        chk("sh_addr", bus.data_addr, 32'h206);
        slave(1'b1, 1'b0, 32'h0);
        tick();
        slave(1'b0, 1'b1, 32'h0);
        #1;
        chk("sh_wait_stall", 32'(stallreq), 32'h1);
        tick();
        slave(1'b0, 1'b0, 32'h0);
        #1;
        chk("sh_done_stall", 32'(stallreq), 32'h0);
        chk("sh_wreg", 32'(wreg_o), 32'h0);
        retire();

        // SB replicates the low byte
        set_op(EXE_SB_OP, 32'h001, 32'h7777_775A, 5'd0, 1'b0);
        tick();
        chk("sb_wdata", bus.data_wdata, 32'h5A5A_5A5A);
        chk("sb_size", 32'(bus.data_size), 32'h0);
        slave(1'b1, 1'b1, 32'h0);
        tick();
        slave(1'b0, 1'b0, 32'h0);
        retire();

        // Misaligned load and store
        set_op(EXE_LW_OP, 32'h101, 32'h0, 5'd4, 1'b1);
        #1;
        chk("adel_exc", except_type_o, 32'h0000_0010);
        chk("adel_bad", bad_vaddr_o, 32'h101);
        chk("adel_stall", 32'(stallreq), 32'h0);
        chk("adel_wreg", 32'(wreg_o), 32'h0);
        tick();
        chk("adel_req", 32'(bus.data_req), 32'h0);
        set_op(EXE_SW_OP, 32'h102, 32'h0, 5'd0, 1'b0);
        #1;
        chk("ades_exc", except_type_o, 32'h0000_0020);
        tick();
        chk("ades_req", 32'(bus.data_req), 32'h0);

        // Upstream exception suppresses the access
        set_op(EXE_LW_OP, 32'h100, 32'h0, 5'd4, 1'b1);
        mem_except_type_i = 32'h0000_0100;
        #1;
        chk("upexc_exc", except_type_o, 32'h0000_0100);
        chk("upexc_stall", 32'(stallreq), 32'h0);
        tick();
        chk("upexc_req", 32'(bus.data_req), 32'h0);

        // Flush in WAIT drains the late data_ok
        set_op(EXE_LW_OP, 32'h300, 32'h0, 5'd6, 1'b1);
        tick();
        slave(1'b1, 1'b0, 32'h0);
        tick();
        slave(1'b0, 1'b0, 32'h0);
        flush = 1'b1;
        #1;
        chk("flush_wreg", 32'(wreg_o), 32'h0);
        chk("flush_exc", except_type_o, 32'h0);
        tick();
        flush = 1'b0;
        set_op(8'h00, 32'h0, 32'h0, 5'd0, 1'b0);
        #1;
        chk("drain_stall", 32'(stallreq), 32'h1);
        chk("drain_req", 32'(bus.data_req), 32'h0);
        tick();
        chk("drain_stall2", 32'(stallreq), 32'h1);
        slave(1'b0, 1'b1, 32'h0000_0005);
        tick();
        slave(1'b0, 1'b0, 32'h0);
        #1;
        chk("drain_exit_stall", 32'(stallreq), 32'h0);
        chk("drain_exit_wreg", 32'(wreg_o), 32'h0);
        chk("drain_exit_wdata", wdata_o, 32'h0);

        // Flush in REQ before addr_ok drops the request
        set_op(EXE_LW_OP, 32'h304, 32'h0, 5'd6, 1'b1);
        tick();
        chk("freq_req", 32'(bus.data_req), 32'h1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        set_op(8'h00, 32'h0, 32'h0, 5'd0, 1'b0);
        #1;
        chk("freq_dropped", 32'(bus.data_req), 32'h0);
        chk("freq_stall", 32'(stallreq), 32'h0);

        // Result held in DONE until advance
        run_load(EXE_LW_OP, 32'h400, 32'hCAFE_0001);
        for (int i = 0; i < 3; i++) begin
            chk("hold_wdata", wdata_o, 32'hCAFE_0001);
            chk("hold_stall", 32'(stallreq), 32'h0);
            chk("hold_req", 32'(bus.data_req), 32'h0);
            tick();
        end
        retire();
        chk("hold_consumed_stall", 32'(stallreq), 32'h0);
        tick();
        chk("hold_consumed_req", 32'(bus.data_req), 32'h0);

        // Reset during REQ abandons the transaction
        set_op(EXE_LW_OP, 32'h500, 32'h0, 5'd8, 1'b1);
        tick();
        chk("rreq_req", 32'(bus.data_req), 32'h1);
        rst = 1'b1;
        tick();
        chk("rreq_req_after", 32'(bus.data_req), 32'h0);
        chk("rreq_wd", 32'(wd_o), 32'h0);
        chk("rreq_wreg", 32'(wreg_o), 32'h0);
        chk("rreq_wdata", wdata_o, 32'h0);
        chk("rreq_stall", 32'(stallreq), 32'h0);
        rst = 1'b0;
        set_op(8'h00, 32'h0, 32'h0, 5'd0, 1'b0);
        tick();
        chk("rreq_idle_req", 32'(bus.data_req), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
